// File: rtl/jt89_regs.sv
// jt89_regs : CPU-facing register file of the JT89 PSG.
//
// Decodes SN76489 latch/data bytes into the three 10-bit tone periods, the
// four 4-bit attenuations and the 3-bit noise control. It also models the
// chip READY line, which stays low for READY_CYCLES clk_en ticks after every
// accepted write.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   clk_en       clock enable; all state moves only on enabled edges
//   din[7:0]     CPU data byte
//   cs_n, wr_n   chip select / write strobe, both active low
//   ready        1 = idle and able to accept a write, 0 = busy
//   tone0..2     tone periods (0 is stored as-is; downstream reads it as 1024)
//   vol0..3      attenuations; 0 is loudest, F is off (vol3 = noise channel)
//   ctrl3        noise control: [2] white/periodic, [1:0] rate
//   clr          one-tick pulse on every noise-control write (LFSR reseed)
module jt89_regs #(
  parameter int         READY_CYCLES = 32,
  parameter logic [3:0] VOL_RST      = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic [7:0] din,
  input  logic       cs_n,
  input  logic       wr_n,
  output logic       ready,
  output logic [9:0] tone0,
  output logic [9:0] tone1,
  output logic [9:0] tone2,
  output logic [3:0] vol0,
  output logic [3:0] vol1,
  output logic [3:0] vol2,
  output logic [3:0] vol3,
  output logic [2:0] ctrl3,
  output logic       clr
);

  localparam logic [5:0] BUSY_LOAD = 6'(READY_CYCLES - 1);

  logic [9:0] tone_reg [0:2];
  logic [3:0] vol_reg  [0:3];
  logic [2:0] ctrl3_reg;
  logic [2:0] latch_reg;     // {channel[1:0], type}; type 1 = volume
  logic       clr_reg;
  logic       ready_reg;
  logic       last_act_reg;
  logic [5:0] busy_cnt_reg;

  logic       act;
  logic       accept;
  logic       is_latch;
  logic [2:0] eff_latch;
  logic [1:0] ch;
  logic       is_vol;
  logic       noise_wr;
  logic [2:0] tone_lo_we;
  logic [2:0] tone_hi_we;
  logic [3:0] vol_we;

  assign act      = !cs_n && !wr_n;
  // Only a fresh strobe edge seen while idle counts; anything else is dropped.
  assign accept   = act && !last_act_reg && ready_reg;
  assign is_latch = din[7];
  // A latch byte addresses the register it names itself; a data byte uses
  // the register stored by the most recent latch byte.
  assign eff_latch = is_latch ? din[6:4] : latch_reg;
  assign ch        = eff_latch[2:1];
  assign is_vol    = eff_latch[0];
  assign noise_wr  = accept && !is_vol && (ch == 2'd3);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_tone_we
      assign tone_lo_we[gi] = accept &&  is_latch && !is_vol && (ch == 2'(gi));
      assign tone_hi_we[gi] = accept && !is_latch && !is_vol && (ch == 2'(gi));
    end
    for (gi = 0; gi < 4; gi++) begin : g_vol_we
      assign vol_we[gi] = accept && is_vol && (ch == 2'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) tone_reg[i] <= '0;
      for (int i = 0; i < 4; i++) vol_reg[i]  <= VOL_RST;
      ctrl3_reg    <= '0;
      latch_reg    <= '0;
      clr_reg      <= 1'b0;
      ready_reg    <= 1'b1;
      last_act_reg <= 1'b0;
      busy_cnt_reg <= '0;
    end else if (clk_en) begin
      last_act_reg <= act;
      clr_reg      <= noise_wr;

      for (int i = 0; i < 3; i++) begin
        if (tone_lo_we[i]) tone_reg[i][3:0] <= din[3:0];
        if (tone_hi_we[i]) tone_reg[i][9:4] <= din[5:0];
      end
      for (int i = 0; i < 4; i++) begin
        if (vol_we[i]) vol_reg[i] <= din[3:0];
      end
      if (noise_wr) ctrl3_reg <= din[2:0];

      if (accept) begin
        if (is_latch) latch_reg <= din[6:4];
        ready_reg    <= 1'b0;
        busy_cnt_reg <= BUSY_LOAD;
      end else if (!ready_reg) begin
        // Load value N-1 plus the terminal edge gives exactly N low ticks.
        if (busy_cnt_reg == 6'd0) ready_reg <= 1'b1;
        else                      busy_cnt_reg <= busy_cnt_reg - 6'd1;
      end
    end
  end

  assign ready = ready_reg;
  assign tone0 = tone_reg[0];
  assign tone1 = tone_reg[1];
  assign tone2 = tone_reg[2];
  assign vol0  = vol_reg[0];
  assign vol1  = vol_reg[1];
  assign vol2  = vol_reg[2];
  assign vol3  = vol_reg[3];
  assign ctrl3 = ctrl3_reg;
  assign clr   = clr_reg;

endmodule

// File: tb/tb_jt89_regs.sv
// tb_jt89_regs : directed-vector bench for jt89_regs.
// Inputs change on the falling clock edge; outputs are sampled 1 ns after the
// enabled rising edge. clk_en is high for one clock and then low for one clock.
module tb_jt89_regs;

  logic       clk;
  logic       rst;
  logic       clk_en;
  logic [7:0] din;
  logic       cs_n;
  logic       wr_n;
  logic       ready;
  logic [9:0] tone0, tone1, tone2;
  logic [3:0] vol0, vol1, vol2, vol3;
  logic [2:0] ctrl3;
  logic       clr;

  int vectors;
  int miscompares;
  int n;

  jt89_regs #(.READY_CYCLES(32), .VOL_RST(4'hF)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .din    (din),
    .cs_n   (cs_n),
    .wr_n   (wr_n),
    .ready  (ready),
    .tone0  (tone0),
    .tone1  (tone1),
    .tone2  (tone2),
    .vol0   (vol0),
    .vol1   (vol1),
    .vol2   (vol2),
    .vol3   (vol3),
    .ctrl3  (ctrl3),
    .clr    (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // One enabled clock edge, sampled 1 ns later, followed by one disabled clock.
  task automatic tick();
    @(negedge clk) clk_en = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk) clk_en = 1'b0;
  endtask

  // Strobe held across exactly one enabled edge, then released.
  task automatic write(input logic [7:0] d);
    din  = d;
    cs_n = 1'b0;
    wr_n = 1'b0;
    tick();
    cs_n = 1'b1;
    wr_n = 1'b1;
  endtask

  // Ticks until ready rises; a timeout returns a value no check expects.
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!ready && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst    = 1'b1;
    clk_en = 1'b0;
    din    = 8'h00;
    cs_n   = 1'b1;
    wr_n   = 1'b1;

    // 1: reset values, before any clock edge
    #1;
    check("rst ready", 16'(ready), 16'h1);
    check("rst tone0", 16'(tone0), 16'h0);
    check("rst tone1", 16'(tone1), 16'h0);
    check("rst tone2", 16'(tone2), 16'h0);
    check("rst vol0",  16'(vol0),  16'hF);
    check("rst vol1",  16'(vol1),  16'hF);
    check("rst vol2",  16'(vol2),  16'hF);
    check("rst vol3",  16'(vol3),  16'hF);
    check("rst ctrl3", 16'(ctrl3), 16'h0);
    check("rst clr",   16'(clr),   16'h0);
    @(negedge clk) rst = 1'b0;

    // Reset latch selects tone0: a data byte lands in tone0[9:4]
    write(8'h3F);
    check("latch0 tone0", 16'(tone0), 16'h3F0);
    wait_ready(n);

    // 2: tone0 latch + data, 32-tick busy each
    write(8'h8E);
    check("t2 tone0 lo", 16'(tone0), 16'h3FE);
    check("t2 busy", 16'(ready), 16'h0);
    wait_ready(n);
    check("t2 busy ticks a", 16'(n), 16'd32);
    write(8'h0F);
    check("t2 tone0", 16'(tone0), 16'h0FE);
    wait_ready(n);
    check("t2 busy ticks b", 16'(n), 16'd32);

    // 3: noise control via latch and via data, clr pulses
    write(8'hE5);
    check("t3 ctrl3 a", 16'(ctrl3), 16'h5);
    check("t3 clr a", 16'(clr), 16'h1);
    @(posedge clk); #1;  // disabled edge: pulse must persist
    check("t3 clr hold", 16'(clr), 16'h1);
    tick();
    check("t3 clr drop", 16'(clr), 16'h0);
    wait_ready(n);
    check("t3 busy ticks", 16'(n), 16'd31);
    write(8'h02);
    check("t3 ctrl3 b", 16'(ctrl3), 16'h2);
    check("t3 clr b", 16'(clr), 16'h1);
    tick();
    check("t3 clr b drop", 16'(clr), 16'h0);
    wait_ready(n);

    // 4: volume latch then data on the noise channel
    write(8'hF3);
    check("t4 vol3 a", 16'(vol3), 16'h3);
    check("t4 clr", 16'(clr), 16'h0);
    wait_ready(n);
    write(8'h07);
    check("t4 vol3 b", 16'(vol3), 16'h7);
    check("t4 ctrl3", 16'(ctrl3), 16'h2);
    check("t4 tone0", 16'(tone0), 16'h0FE);
    wait_ready(n);

    // 5: second write two ticks after the first is discarded
    write(8'h9A);
    check("t5 vol0", 16'(vol0), 16'hA);
    tick();
    write(8'h85);
    check("t5 drop tone0", 16'(tone0), 16'h0FE);
    check("t5 drop vol0", 16'(vol0), 16'hA);
    wait_ready(n);
    check("t5 busy ticks", 16'(n), 16'd30);
    write(8'h03);  // latch must still be vol0
    check("t5 vol0 data", 16'(vol0), 16'h3);
    check("t5 tone0 kept", 16'(tone0), 16'h0FE);
    // Strobe held low across the busy window must not retrigger
    din  = 8'h81;
    cs_n = 1'b0;
    wr_n = 1'b0;
    wait_ready(n);
    check("t5 held busy", 16'(n), 16'd32);
    for (int i = 0; i < 3; i++) tick();
    check("t5 held ready", 16'(ready), 16'h1);
    check("t5 held tone0", 16'(tone0), 16'h0FE);
    cs_n = 1'b1;
    wr_n = 1'b1;
    tick();

    // 6: reset in the middle of a busy window
    write(8'h85);
    check("t6 tone0", 16'(tone0), 16'h0F5);
    for (int i = 0; i < 9; i++) tick();
    check("t6 busy", 16'(ready), 16'h0);
    rst = 1'b1;
    #1;
    check("t6 ready", 16'(ready), 16'h1);
    check("t6 tone0", 16'(tone0), 16'h0);
    check("t6 vol0", 16'(vol0), 16'hF);
    check("t6 vol3", 16'(vol3), 16'hF);
    check("t6 ctrl3", 16'(ctrl3), 16'h0);
    check("t6 clr", 16'(clr), 16'h0);
    @(negedge clk) rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
